// File: rtl/switch_debouncer_pkg.sv
// Shared types and defaults for the dual-channel switch debouncer.
package switch_debouncer_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_WAIT_HIGH = 2'd1,
        ST_HIGH      = 2'd2,
        ST_WAIT_LOW  = 2'd3
    } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One channel: 2-flop synchroniser, debounce FSM/counter, registered level and edge pulses.
module debounce_channel #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);
    import switch_debouncer_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

    logic             s1, s2;
    db_state_t        state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_LOW;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (s2) begin
                        state <= ST_WAIT_HIGH;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A glitch back to the old level on the accepting edge still cancels.
                    if (!s2) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ST_HIGH;
                        db    <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!s2) begin
                        state <= ST_WAIT_LOW;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                ST_WAIT_LOW: begin
                    if (s2) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        state <= ST_LOW;
                        db    <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Two independent debounced switch channels feeding the AND gate's x and y inputs.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_x,
    input  logic raw_y,
    output logic x_db,
    output logic y_db,
    output logic x_rise,
    output logic x_fall,
    output logic y_rise,
    output logic y_fall
);

    debounce_channel #(.N(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_x (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_x),
        .db    (x_db),
        .rise  (x_rise),
        .fall  (x_fall)
    );

    debounce_channel #(.N(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_y (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_y),
        .db    (y_db),
        .rise  (y_rise),
        .fall  (y_fall)
    );

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with N=4: directed scenarios plus random bouncing vs a run-length model.
module tb_switch_debouncer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic raw_x = 1'b0, raw_y = 1'b0;
    logic x_db, y_db, x_rise, x_fall, y_rise, y_fall;

    int checks = 0;
    int errors = 0;

    // Model: raw seen by the debouncer two edges late; db flips after N consecutive differing samples.
    logic m_s1 [2];
    logic m_s2 [2];
    logic m_db [2];
    logic m_rise [2];
    logic m_fall [2];
    int   m_run [2];

    always #5 clk = ~clk;

    switch_debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_x  (raw_x),
        .raw_y  (raw_y),
        .x_db   (x_db),
        .y_db   (y_db),
        .x_rise (x_rise),
        .x_fall (x_fall),
        .y_rise (y_rise),
        .y_fall (y_fall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_db[c] = 1'b0;
            m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_run[c] = 0;
        end
    endtask

    // One clock edge: advance the model, then check every output 1 time unit later.
    task automatic step();
        logic r [2];
        r[0] = raw_x;
        r[1] = raw_y;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (m_s2[c] !== m_db[c]) begin
                    m_run[c]++;
                    if (m_run[c] == N) begin
                        m_db[c]   = m_s2[c];
                        m_rise[c] = m_s2[c];
                        m_fall[c] = ~m_s2[c];
                        m_run[c]  = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = r[c];
            end
        end
        #1;
        chk("x_db",   x_db,   m_db[0]);
        chk("y_db",   y_db,   m_db[1]);
        chk("x_rise", x_rise, m_rise[0]);
        chk("x_fall", x_fall, m_fall[0]);
        chk("y_rise", y_rise, m_rise[1]);
        chk("y_fall", y_fall, m_fall[1]);
        chk("x_excl", x_rise & x_fall, 1'b0);
        chk("y_excl", y_rise & y_fall, 1'b0);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_dut(input logic rx, input logic ry);
        raw_x = rx;
        raw_y = ry;
        rst_n = 1'b0;
        model_reset();
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int nrise;
        model_reset();
        rst_n = 1'b0;

        // Reset values with raws high, then release: rise on edge 5.
        raw_x = 1'b1; raw_y = 1'b1;
        #1;
        chk("rst_x_db", x_db, 1'b0);
        chk("rst_y_db", y_db, 1'b0);
        chk("rst_pulses", {x_rise, x_fall, y_rise, y_fall}, 4'b0);
        steps(3);
        rst_n = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            if (e < 5) chk("rel_pre_db", {x_db, y_db}, 2'b00);
            if (e == 5) chk("rel_edge5", {x_db, y_db, x_rise, y_rise}, 4'b1111);
            if (e == 6) chk("rel_pulse_end", {x_rise, y_rise}, 2'b00);
        end

        // Clean press on x.
        reset_dut(1'b0, 1'b0);
        steps(8);
        raw_x = 1'b1;
        nrise = 0;
        for (int e = 0; e < 20; e++) begin
            step();
            nrise += int'(x_rise);
            if (e == 4) chk("press_e4_db", x_db, 1'b0);
            if (e == 5) chk("press_e5", {x_db, x_rise}, 2'b11);
        end
        chk("press_rise_cnt", nrise, 1);
        chk("press_y_db", y_db, 1'b0);

        // Bounce rejection.
        reset_dut(1'b0, 1'b0);
        steps(8);
        nrise = 0;
        for (int k = 0; k < 4; k++) begin
            raw_x = (k % 2 == 0);
            for (int i = 0; i < 2; i++) begin
                step();
                nrise += int'(x_rise);
                chk("bounce_db", x_db, 1'b0);
            end
        end
        raw_x = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            nrise += int'(x_rise);
            if (e == 4) chk("bounce_e4_db", x_db, 1'b0);
            if (e == 5) chk("bounce_e5_db", x_db, 1'b1);
        end
        chk("bounce_rise_cnt", nrise, 1);

        // Release glitch of 3 cycles, then sustained low.
        raw_x = 1'b0;
        steps(3);
        raw_x = 1'b1;
        nrise = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            nrise += int'(x_fall);
        end
        chk("glitch_db", x_db, 1'b1);
        chk("glitch_fall_cnt", nrise, 0);
        raw_x = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            step();
            if (e == 4) chk("rel_e4_db", x_db, 1'b1);
            if (e == 5) chk("rel_e5", {x_db, x_fall}, 2'b01);
            if (e == 6) chk("rel_e6_fall", x_fall, 1'b0);
        end

        // Reset asserted mid-count on y.
        reset_dut(1'b0, 1'b0);
        steps(8);
        raw_y = 1'b1;
        steps(4);
        chk("mid_cnt_running", 32'(dut.u_y.cnt), 32'd2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_db", y_db, 1'b0);
        chk("mid_rst_cnt", 32'(dut.u_y.cnt), 32'd0);
        steps(2);
        rst_n = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            if (e < 5) chk("mid_no_rise", {y_db, y_rise}, 2'b00);
            if (e == 5) chk("mid_e5", {y_db, y_rise}, 2'b11);
        end

        // Simultaneous channels.
        reset_dut(1'b0, 1'b0);
        steps(8);
        raw_x = 1'b1; raw_y = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            step();
            if (e == 4) chk("sim_e4_and", x_db & y_db, 1'b0);
            if (e == 5) chk("sim_e5", {x_db, y_db, x_rise, y_rise}, 4'b1111);
        end
        chk("sim_and", x_db & y_db, 1'b1);

        // Random bouncing, alternating noisy and calmer phases.
        reset_dut(1'b0, 1'b0);
        for (int p = 0; p < 8; p++) begin
            int rate = (p % 2 == 0) ? 2 : 9;
            for (int i = 0; i < 80; i++) begin
                if ($urandom_range(0, rate) == 0) raw_x = ~raw_x;
                if ($urandom_range(0, rate) == 0) raw_y = ~raw_y;
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
